mont_mul: RTL and testbench



---
 rtl/mont_mul_pkg.sv | 19 +
 rtl/mont_mul_step.sv | 24 ++
 rtl/mont_mul.sv | 112 +++++++++++
 tb/tb_mont_mul.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_mul_pkg.sv
// Shared types and constants for the radix-2 Montgomery multiplier.
// The build macro MONT_MUL_FINAL_SUB_EN selects the final conditional subtraction.
package mont_mul_pkg;

    localparam int MM_WIDTH_DEFAULT = 2048;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } mm_state_e;

    // Counter must reach WIDTH itself, hence one bit beyond clog2.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mont_mul_step.sv
// One radix-2 Montgomery iteration: A' = (A + xbit*y + q*n) / 2, q chosen to make the sum even.
module mont_mul_step
    import mont_mul_pkg::*;
#(
    parameter int WIDTH = MM_WIDTH_DEFAULT
) (
    input  logic [WIDTH+1:0] a_i,
    input  logic [WIDTH-1:0] yr_i,
    input  logic [WIDTH-1:0] nr_i,
    input  logic             xbit_i,
    output logic [WIDTH+1:0] a_o
);

    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_red;

    // A < 2n keeps A + y + n below 4n, so WIDTH+2 bits always suffice.
    always_comb begin
        t_add = a_i + (xbit_i ? {2'b00, yr_i} : '0);
        t_red = t_add[0] ? t_add + {2'b00, nr_i} : t_add;
        a_o   = t_red >> 1;
    end

endmodule

// File: rtl/mont_mul.sv
// Sequential Montgomery multiplier: result = x*y*2^-WIDTH mod n, one bit of x per clock.
// Define MONT_MUL_FINAL_SUB_EN to add the FINAL subtraction state (result in [0,n)).
module mont_mul
    import mont_mul_pkg::*;
#(
    parameter int WIDTH = MM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             mm_rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] n,
    output logic             mm_finish,
    output logic [WIDTH-1:0] result
);

    localparam int CW = cnt_width(WIDTH);

    mm_state_e        state_q, state_d;
    logic [WIDTH-1:0] xr_q, xr_d;
    logic [WIDTH-1:0] yr_q, yr_d;
    logic [WIDTH-1:0] nr_q, nr_d;
    logic [WIDTH+1:0] a_q, a_d;
    logic [CW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             finish_q, finish_d;

    logic [WIDTH+1:0] a_step;
    logic             last_iter;

    assign last_iter = (i_q == CW'(WIDTH - 1));

    mont_mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i    (a_q),
        .yr_i   (yr_q),
        .nr_i   (nr_q),
        .xbit_i (xr_q[i_q[CW-2:0]]),
        .a_o    (a_step)
    );

    always_comb begin
        state_d  = state_q;
        xr_d     = xr_q;
        yr_d     = yr_q;
        nr_d     = nr_q;
        a_d      = a_q;
        i_d      = i_q;
        result_d = result_q;
        finish_d = finish_q;
        case (state_q)
            LOAD: begin
                xr_d    = x;
                yr_d    = y;
                nr_d    = n;
                a_d     = '0;
                i_d     = '0;
                state_d = ITER;
            end
            ITER: begin
                a_d = a_step;
                i_d = i_q + 1'b1;
                if (last_iter) begin
`ifdef MONT_MUL_FINAL_SUB_EN
                    state_d = FINAL;
`else
                    // Unreduced exit: result lies in [0,2n) and is only exact for n < 2^(WIDTH-1).
                    result_d = WIDTH'(a_step);
                    finish_d = 1'b1;
                    state_d  = DONE;
`endif
                end
            end
            FINAL: begin
`ifdef MONT_MUL_FINAL_SUB_EN
                result_d = (a_q >= {2'b00, nr_q}) ? WIDTH'(a_q - {2'b00, nr_q}) : WIDTH'(a_q);
                finish_d = 1'b1;
`endif
                state_d  = DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mm_rst) begin
            state_q  <= LOAD;
            a_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            i_q      <= i_d;
            result_q <= result_d;
            finish_q <= finish_d;
        end
    end

    // Operand copies need no reset: LOAD always overwrites them before use.
    always_ff @(posedge clk) begin
        xr_q <= xr_d;
        yr_q <= yr_d;
        nr_q <= nr_d;
    end

    assign mm_finish = finish_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mont_mul.sv
// Directed and random bench for mont_mul at WIDTH 8, 64 and 2048.
// Adapts expected latency/range to MONT_MUL_FINAL_SUB_EN.
module tb_mont_mul;

`ifdef MONT_MUL_FINAL_SUB_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 1;
`endif
    localparam int LAT8    = 8 + EXTRA;
    localparam int LAT64   = 64 + EXTRA;
    localparam int LAT2048 = 2048 + EXTRA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst8 = 1'b1, fin8;
    logic [7:0]    x8 = '0, y8 = '0, n8 = 8'd13, res8;
    logic          rst64 = 1'b1, fin64;
    logic [63:0]   x64 = '0, y64 = '0, n64 = 64'd13, res64;
    logic          rst2k = 1'b1, fin2k;
    logic [2047:0] x2k = '0, y2k = '0, n2k = 2048'd13, res2k;

    int n_checks = 0;
    int n_fail   = 0;

    mont_mul #(.WIDTH(8)) u_dut8 (
        .clk(clk), .mm_rst(rst8), .x(x8), .y(y8), .n(n8),
        .mm_finish(fin8), .result(res8)
    );
    mont_mul #(.WIDTH(64)) u_dut64 (
        .clk(clk), .mm_rst(rst64), .x(x64), .y(y64), .n(n64),
        .mm_finish(fin64), .result(res64)
    );
    mont_mul #(.WIDTH(2048)) u_dut2k (
        .clk(clk), .mm_rst(rst2k), .x(x2k), .y(y2k), .n(n2k),
        .mm_finish(fin2k), .result(res2k)
    );

    function automatic logic [127:0] mulmod(input logic [127:0] a, input logic [127:0] b,
                                            input logic [127:0] m);
        return (a * b) % m;
    endfunction

    // x*y*2^-w mod m, using 2^-1 = (m+1)/2 raised to the w-th power.
    function automatic logic [127:0] ref_mont(input logic [127:0] a, input logic [127:0] b,
                                              input logic [127:0] m, input int w);
        logic [127:0] r, base;
        int e;
        r    = 128'd1;
        base = (m + 128'd1) >> 1;
        e    = w;
        while (e > 0) begin
            if ((e & 1) != 0) r = mulmod(r, base, m);
            base = mulmod(base, base, m);
            e    = e >> 1;
        end
        return mulmod(mulmod(a % m, b % m, m), r, m);
    endfunction

    // Maps a DUT result to its residue, or all-ones if it is outside the allowed range.
    function automatic logic [127:0] canon(input logic [127:0] r, input logic [127:0] m);
`ifdef MONT_MUL_FINAL_SUB_EN
        return (r >= m) ? '1 : r;
`else
        if (r >= (m << 1)) return '1;
        return (r >= m) ? r - m : r;
`endif
    endfunction

    task automatic run8(input logic [7:0] xv, input logic [7:0] yv, input logic [7:0] nv,
                        output logic [127:0] rv, output int lat);
        if (!rst8) begin
            @(negedge clk);
            rst8 = 1'b1;
        end
        @(negedge clk);
        x8 = xv; y8 = yv; n8 = nv; rst8 = 1'b0;
        lat = 0;
        for (int k = 1; k <= LAT8 + 8; k++) begin
            @(posedge clk); #1;
            if (fin8) begin lat = k; break; end
        end
        rv = 128'(res8);
    endtask

    task automatic run64(input logic [63:0] xv, input logic [63:0] yv, input logic [63:0] nv,
                         output logic [127:0] rv, output int lat);
        if (!rst64) begin
            @(negedge clk);
            rst64 = 1'b1;
        end
        @(negedge clk);
        x64 = xv; y64 = yv; n64 = nv; rst64 = 1'b0;
        lat = 0;
        for (int k = 1; k <= LAT64 + 8; k++) begin
            @(posedge clk); #1;
            if (fin64) begin lat = k; break; end
        end
        rv = 128'(res64);
    endtask

    task automatic run2k(input logic [127:0] xv, input logic [127:0] yv, input logic [127:0] nv,
                         output logic [127:0] rv, output int lat);
        if (!rst2k) begin
            @(negedge clk);
            rst2k = 1'b1;
        end
        @(negedge clk);
        x2k = 2048'(xv); y2k = 2048'(yv); n2k = 2048'(nv); rst2k = 1'b0;
        lat = 0;
        for (int k = 1; k <= LAT2048 + 8; k++) begin
            @(posedge clk); #1;
            if (fin2k) begin lat = k; break; end
        end
        rv = (|res2k[2047:128]) ? '1 : res2k[127:0];
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (fin8 !== 1'b0)   begin n_fail++; $display("FAIL reset_fin8: got %0b expected 0", fin8); end
        n_checks++; if (res8 !== 8'd0)   begin n_fail++; $display("FAIL reset_res8: got %0d expected 0", res8); end
        n_checks++; if (fin64 !== 1'b0)  begin n_fail++; $display("FAIL reset_fin64: got %0b expected 0", fin64); end
        n_checks++; if (res64 !== 64'd0) begin n_fail++; $display("FAIL reset_res64: got %0d expected 0", res64); end
        n_checks++; if (fin2k !== 1'b0)  begin n_fail++; $display("FAIL reset_fin2048: got %0b expected 0", fin2k); end
        n_checks++; if (res2k !== '0)    begin n_fail++; $display("FAIL reset_res2048: got %0h expected 0", res2k); end
        $display("test_reset: outputs checked at zero");
    endtask

    task automatic test_directed8();
        int xs[4]  = '{5, 1, 12, 0};
        int ys[4]  = '{7, 1, 12, 9};
        int exs[4] = '{1, 3, 3, 0};
        logic [127:0] rv;
        int lat;
        for (int v = 0; v < 4; v++) begin
            run8(8'(xs[v]), 8'(ys[v]), 8'd13, rv, lat);
            $display("directed8: x=%0d y=%0d n=13 result=%0d latency=%0d", xs[v], ys[v], rv, lat);
            n_checks++;
            if (lat !== LAT8) begin
                n_fail++; $display("FAIL directed8_latency: got %0d expected %0d", lat, LAT8);
            end
            n_checks++;
            if (canon(rv, 128'd13) !== 128'(exs[v])) begin
                n_fail++; $display("FAIL directed8_result: got %0d expected %0d", rv, exs[v]);
            end
        end
    endtask

    task automatic test_reset_mid8();
        logic [127:0] rv;
        int lat;
        @(negedge clk); rst8 = 1'b1;
        @(negedge clk); x8 = 8'd12; y8 = 8'd12; n8 = 8'd13; rst8 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst8 = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (fin8 !== 1'b0) begin n_fail++; $display("FAIL midreset8_fin: got %0b expected 0", fin8); end
        n_checks++; if (res8 !== 8'd0) begin n_fail++; $display("FAIL midreset8_res: got %0d expected 0", res8); end
        run8(8'd5, 8'd7, 8'd13, rv, lat);
        $display("midreset8: restart x=5 y=7 n=13 result=%0d latency=%0d", rv, lat);
        n_checks++; if (lat !== LAT8) begin n_fail++; $display("FAIL midreset8_latency: got %0d expected %0d", lat, LAT8); end
        n_checks++; if (canon(rv, 128'd13) !== 128'd1) begin n_fail++; $display("FAIL midreset8_result: got %0d expected 1", rv); end
    endtask

    task automatic test_reset_done8();
        @(negedge clk); rst8 = 1'b1;
        @(posedge clk); #1;
        $display("resetdone8: fin=%0b result=%0d", fin8, res8);
        n_checks++; if (fin8 !== 1'b0) begin n_fail++; $display("FAIL resetdone8_fin: got %0b expected 0", fin8); end
        n_checks++; if (res8 !== 8'd0) begin n_fail++; $display("FAIL resetdone8_res: got %0d expected 0", res8); end
    endtask

    task automatic test_wide();
        logic [127:0] xv, yv, nv, rv, ev;
        int lat, drops;
        xv = 128'd953213471;
        yv = 128'd9663486725113;
        nv = 128'd9561345678456161;
        ev = ref_mont(xv, yv, nv, 2048);
        run2k(xv, yv, nv, rv, lat);
        $display("wide2048: result=%0d expected=%0d latency=%0d", rv, ev, lat);
        n_checks++; if (lat !== LAT2048) begin n_fail++; $display("FAIL wide_latency: got %0d expected %0d", lat, LAT2048); end
        n_checks++; if (canon(rv, nv) !== ev) begin n_fail++; $display("FAIL wide_result: got %0d expected %0d", rv, ev); end
        drops = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (fin2k !== 1'b1) drops++;
        end
        n_checks++; if (drops !== 0) begin n_fail++; $display("FAIL wide_hold: got %0d low cycles expected 0", drops); end
    endtask

    task automatic test_reset_mid_wide();
        logic [127:0] rv, ev;
        int lat;
        @(negedge clk); rst2k = 1'b1;
        @(negedge clk); x2k = 2048'd953213471; y2k = 2048'd9663486725113; n2k = 2048'd9561345678456161; rst2k = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk); rst2k = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (fin2k !== 1'b0) begin n_fail++; $display("FAIL midreset2048_fin: got %0b expected 0", fin2k); end
        n_checks++; if (res2k !== '0) begin n_fail++; $display("FAIL midreset2048_res: got %0h expected 0", res2k); end
        ev = ref_mont(128'd5, 128'd7, 128'd13, 2048);
        run2k(128'd5, 128'd7, 128'd13, rv, lat);
        $display("midreset2048: restart x=5 y=7 n=13 result=%0d expected=%0d latency=%0d", rv, ev, lat);
        n_checks++; if (lat !== LAT2048) begin n_fail++; $display("FAIL midreset2048_latency: got %0d expected %0d", lat, LAT2048); end
        n_checks++; if (canon(rv, 128'd13) !== ev) begin n_fail++; $display("FAIL midreset2048_result: got %0d expected %0d", rv, ev); end
    endtask

    task automatic test_random8();
        logic [127:0] rv, ev;
        logic [7:0] nv, xv, yv;
        int lat;
        for (int v = 0; v < 500; v++) begin
`ifdef MONT_MUL_FINAL_SUB_EN
            nv = 8'($urandom_range(1, 127) * 2 + 1);
`else
            nv = 8'($urandom_range(1, 63) * 2 + 1);
`endif
            xv = 8'($urandom % nv);
            yv = 8'($urandom % nv);
            ev = ref_mont(128'(xv), 128'(yv), 128'(nv), 8);
            run8(xv, yv, nv, rv, lat);
            $display("random8: x=%0d y=%0d n=%0d result=%0d expected=%0d latency=%0d", xv, yv, nv, rv, ev, lat);
            n_checks++; if (lat !== LAT8) begin n_fail++; $display("FAIL random8_latency: got %0d expected %0d", lat, LAT8); end
            n_checks++; if (canon(rv, 128'(nv)) !== ev) begin n_fail++; $display("FAIL random8_result: got %0d expected %0d", rv, ev); end
        end
    endtask

    task automatic test_random64();
        logic [127:0] rv, ev;
        logic [63:0] nv, xv, yv;
        int lat;
        for (int v = 0; v < 500; v++) begin
            nv = {$urandom, $urandom} | 64'd1;
`ifndef MONT_MUL_FINAL_SUB_EN
            nv[63] = 1'b0;
`endif
            if (nv < 64'd3) nv = 64'd3;
            xv = {$urandom, $urandom} % nv;
            yv = {$urandom, $urandom} % nv;
            ev = ref_mont(128'(xv), 128'(yv), 128'(nv), 64);
            run64(xv, yv, nv, rv, lat);
            $display("random64: x=%0h y=%0h n=%0h result=%0h expected=%0h latency=%0d", xv, yv, nv, rv, ev, lat);
            n_checks++; if (lat !== LAT64) begin n_fail++; $display("FAIL random64_latency: got %0d expected %0d", lat, LAT64); end
            n_checks++; if (canon(rv, 128'(nv)) !== ev) begin n_fail++; $display("FAIL random64_result: got %0h expected %0h", rv, ev); end
        end
    endtask

    initial begin
        test_reset();
        test_directed8();
        test_reset_mid8();
        test_reset_done8();
        test_wide();
        test_reset_mid_wide();
        test_random8();
        test_random64();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
